// File: rtl/sram_arbiter_2port_pkg.sv
// Shared types for the two-port SRAM arbiter.
// State, port ids and the byte-lane helper.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    ACK
  } sram_arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_id_e;

  localparam logic [3:0] FULL_MASK = 4'b1111;

  // Active-low {ub_n, lb_n} for one 16-bit phase.
  function automatic logic [1:0] lane_n(
    input logic [3:0] mask,
    input logic       hi
  );
    return hi ? ~mask[3:2] : ~mask[1:0];
  endfunction

endpackage

// File: rtl/sram_arbiter_2port_if.sv
// Requester and SRAM pin bundle for the arbiter.
// slave = arbiter side, master = requesters + SRAM.
interface sram_arbiter_2port_if #(
  parameter int ADDR_W = 18
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic [31:0]       o_if_rdata;
  logic              o_if_ack;

  logic              i_ls_req;
  logic              i_ls_we;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [31:0]       i_ls_wdata;
  logic [3:0]        i_ls_bmask;
  logic [31:0]       o_ls_rdata;
  logic              o_ls_ack;

  logic              o_busy;

  logic [ADDR_W-1:0] o_sram_addr;
  logic [15:0]       i_sram_q;
  logic [15:0]       o_sram_d;
  logic              o_sram_d_oe;
  logic              o_sram_ce_n;
  logic              o_sram_we_n;
  logic              o_sram_oe_n;
  logic              o_sram_lb_n;
  logic              o_sram_ub_n;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_rdata, o_if_ack,
    input  i_ls_req, i_ls_we, i_ls_addr,
    input  i_ls_wdata, i_ls_bmask,
    output o_ls_rdata, o_ls_ack,
    output o_busy,
    output o_sram_addr,
    input  i_sram_q,
    output o_sram_d, o_sram_d_oe,
    output o_sram_ce_n, o_sram_we_n,
    output o_sram_oe_n,
    output o_sram_lb_n, o_sram_ub_n
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_rdata, o_if_ack,
    output i_ls_req, i_ls_we, i_ls_addr,
    output i_ls_wdata, i_ls_bmask,
    input  o_ls_rdata, o_ls_ack,
    input  o_busy,
    input  o_sram_addr,
    output i_sram_q,
    input  o_sram_d, o_sram_d_oe,
    input  o_sram_ce_n, o_sram_we_n,
    input  o_sram_oe_n,
    input  o_sram_lb_n, o_sram_ub_n
  );
endinterface

// File: rtl/sram_arbiter_2port_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Bit 0 = IF, bit 1 = LS; owns last_grant.
module rr_arbiter2 #(
  parameter int RR_RESET_LAST = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // Pick the requester that did not win last time.
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (grant_en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
      if (|gnt_o) begin
        last_d = gnt_o[1];
      end
    end
  end

  // Remember the last granted port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= 1'(RR_RESET_LAST);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_arbiter_2port.sv
// Shares one 16-bit SRAM between IF and LS.
// Each 32-bit word runs as two halfword phases.
module sram_arbiter_2port
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = 18,
  parameter int RR_RESET_LAST = 0
) (
  input logic                i_clk,
  input logic                i_rst_n,
  sram_arbiter_2port_if.slave bus
);

  localparam logic [ADDR_W-1:0] ONE =
    ADDR_W'(1);

  sram_arb_state_e   state_q, state_d;
  port_id_e          port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        bmask_q, bmask_d;
  logic [15:0]       rd_lo_q;
  logic [31:0]       if_rdata_q;
  logic [31:0]       ls_rdata_q;
  logic [1:0]        gnt;

  rr_arbiter2 #(
    .RR_RESET_LAST(RR_RESET_LAST)
  ) u_rr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .req_i     ({bus.i_ls_req, bus.i_if_req}),
    .grant_en_i(state_q == IDLE),
    .gnt_o     (gnt)
  );

  // Sequencing and capture of the granted request.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    unique case (state_q)
      IDLE: begin
        if (gnt[1]) begin
          port_d  = PORT_LS;
          we_d    = bus.i_ls_we;
          base_d  = bus.i_ls_addr & ~ONE;
          wdata_d = bus.i_ls_wdata;
          bmask_d = bus.i_ls_bmask;
          state_d = bus.i_ls_we ? WR_LO : RD_LO;
        end else if (gnt[0]) begin
          port_d  = PORT_IF;
          we_d    = 1'b0;
          base_d  = bus.i_if_addr & ~ONE;
          wdata_d = '0;
          bmask_d = FULL_MASK;
          state_d = RD_LO;
        end
      end
      RD_LO:   state_d = RD_HI;
      RD_HI:   state_d = ACK;
      WR_LO:   state_d = WR_HI;
      WR_HI:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      port_q  <= PORT_IF;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
    end
  end

  // Read data: stage low half, publish whole word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_lo_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (state_q == RD_LO) begin
        rd_lo_q <= bus.i_sram_q;
      end
      if (state_q == RD_HI) begin
        if (port_q == PORT_IF) begin
          if_rdata_q <= {bus.i_sram_q, rd_lo_q};
        end else begin
          ls_rdata_q <= {bus.i_sram_q, rd_lo_q};
        end
      end
    end
  end

  // SRAM pins decoded from registered state only.
  always_comb begin
    bus.o_sram_addr = '0;
    bus.o_sram_d    = '0;
    bus.o_sram_d_oe = 1'b0;
    bus.o_sram_ce_n = 1'b1;
    bus.o_sram_we_n = 1'b1;
    bus.o_sram_oe_n = 1'b1;
    bus.o_sram_lb_n = 1'b1;
    bus.o_sram_ub_n = 1'b1;
    unique case (state_q)
      RD_LO, RD_HI: begin
        bus.o_sram_addr = (state_q == RD_HI) ?
                          (base_q | ONE) : base_q;
        bus.o_sram_ce_n = 1'b0;
        bus.o_sram_oe_n = 1'b0;
        bus.o_sram_lb_n = 1'b0;
        bus.o_sram_ub_n = 1'b0;
      end
      WR_LO: begin
        bus.o_sram_addr = base_q;
        bus.o_sram_ce_n = 1'b0;
        bus.o_sram_we_n = 1'b0;
        bus.o_sram_d_oe = 1'b1;
        bus.o_sram_d    = wdata_q[15:0];
        {bus.o_sram_ub_n, bus.o_sram_lb_n} =
          lane_n(bmask_q, 1'b0);
      end
      WR_HI: begin
        bus.o_sram_addr = base_q | ONE;
        bus.o_sram_ce_n = 1'b0;
        bus.o_sram_we_n = 1'b0;
        bus.o_sram_d_oe = 1'b1;
        bus.o_sram_d    = wdata_q[31:16];
        {bus.o_sram_ub_n, bus.o_sram_lb_n} =
          lane_n(bmask_q, 1'b1);
      end
      default: begin
        bus.o_sram_addr = '0;
      end
    endcase
  end

  // Requester-side outputs.
  always_comb begin
    bus.o_if_ack   = (state_q == ACK) &&
                     (port_q == PORT_IF);
    bus.o_ls_ack   = (state_q == ACK) &&
                     (port_q == PORT_LS);
    bus.o_if_rdata = if_rdata_q;
    bus.o_ls_rdata = ls_rdata_q;
    bus.o_busy     = (state_q != IDLE);
  end

endmodule

// File: tb/tb_sram_arbiter_2port.sv
// Bench for sram_arbiter_2port.
// Pin-level SRAM model plus word-level reference.
module tb_sram_arbiter_2port;

  localparam int AW = 18;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_2port_if #(.ADDR_W(AW)) bus ();

  sram_arbiter_2port #(
    .ADDR_W       (AW),
    .RR_RESET_LAST(0)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  bit [15:0] sram_mem [DEPTH];
  bit [15:0] ref_mem  [DEPTH];
  logic [31:0] exp_rd [2];
  int tests = 0;
  int fails = 0;

  assign bus.i_sram_q =
    (!bus.o_sram_ce_n && !bus.o_sram_oe_n) ?
    sram_mem[bus.o_sram_addr] : 16'h0;

  always @(posedge clk) begin
    if (!bus.o_sram_ce_n && !bus.o_sram_we_n) begin
      if (!bus.o_sram_lb_n)
        sram_mem[bus.o_sram_addr][7:0] =
          bus.o_sram_d[7:0];
      if (!bus.o_sram_ub_n)
        sram_mem[bus.o_sram_addr][15:8] =
          bus.o_sram_d[15:8];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_read(
    input logic [AW-1:0] b);
    return {ref_mem[b + 1], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [AW-1:0] b,
                           input logic [31:0] wd,
                           input logic [3:0] bm);
    logic [31:0] w;
    w = ref_read(b);
    for (int i = 0; i < 4; i++)
      if (bm[i]) w[8*i +: 8] = wd[8*i +: 8];
    ref_mem[b]     = w[15:0];
    ref_mem[b + 1] = w[31:16];
  endtask

  function automatic logic [31:0] pins();
    return {8'h0, bus.o_sram_addr,
            bus.o_sram_ce_n, bus.o_sram_we_n,
            bus.o_sram_oe_n, bus.o_sram_d_oe,
            bus.o_sram_ub_n, bus.o_sram_lb_n};
  endfunction

  function automatic logic [31:0] exp_pins(
    input logic [AW-1:0] a, input bit wr,
    input logic [1:0] lanes_n);
    return {8'h0, a, 1'b0, !wr, wr, wr,
            wr ? lanes_n : 2'b00};
  endfunction

  function automatic logic [31:0] idle_pins();
    return {8'h0, {AW{1'b0}}, 6'b111011};
  endfunction

  task automatic drop_reqs();
    bus.i_if_req = 1'b0;
    bus.i_ls_req = 1'b0;
  endtask

  // One transaction from an idle arbiter.
  task automatic run_txn(input bit port,
                         input bit we,
                         input logic [AW-1:0] addr,
                         input logic [31:0] wd,
                         input logic [3:0] bm,
                         input bit drop_early);
    logic [AW-1:0] b;
    logic [3:0] em;
    bit ewe;
    b   = addr & ~AW'(1);
    ewe = port ? we : 1'b0;
    em  = port ? bm : 4'hF;
    if (port) begin
      bus.i_ls_req   = 1'b1;
      bus.i_ls_we    = we;
      bus.i_ls_addr  = addr;
      bus.i_ls_wdata = wd;
      bus.i_ls_bmask = bm;
    end else begin
      bus.i_if_req  = 1'b1;
      bus.i_if_addr = addr;
    end
    step();
    if (drop_early) begin
      drop_reqs();
      bus.i_ls_addr  = ~addr;
      bus.i_ls_wdata = ~wd;
      bus.i_ls_bmask = ~bm;
      bus.i_if_addr  = ~addr;
    end
    chk("busy_lo", bus.o_busy, 1);
    chk("pins_lo", pins(),
        exp_pins(b, ewe, ~em[1:0]));
    if (ewe) chk("d_lo", bus.o_sram_d, wd[15:0]);
    step();
    chk("pins_hi", pins(),
        exp_pins(b + 1, ewe, ~em[3:2]));
    if (ewe) chk("d_hi", bus.o_sram_d, wd[31:16]);
    step();
    if (ewe) ref_write(b, wd, em);
    else exp_rd[port] = ref_read(b);
    chk("ack_own", port ? bus.o_ls_ack
                        : bus.o_if_ack, 1);
    chk("ack_other", port ? bus.o_if_ack
                          : bus.o_ls_ack, 0);
    chk("pins_ack", pins(), idle_pins());
    chk("if_rdata", bus.o_if_rdata, exp_rd[0]);
    chk("ls_rdata", bus.o_ls_rdata, exp_rd[1]);
    drop_reqs();
    step();
    chk("ack_pulse",
        {bus.o_if_ack, bus.o_ls_ack}, 0);
    chk("busy_end", bus.o_busy, 0);
    if (ewe) begin
      chk("mem_lo", sram_mem[b], ref_mem[b]);
      chk("mem_hi", sram_mem[b + 1],
          ref_mem[b + 1]);
    end
  endtask

  initial begin
    int cyc;
    int ack_cyc[$];
    bit ack_port[$];
    bit rr_if;
    bit rr_ls;
    logic [AW-1:0] a;

    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = 16'($urandom);
      ref_mem[i]  = sram_mem[i];
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    bus.i_if_req   = 1'b1;
    bus.i_if_addr  = 18'h00040;
    bus.i_ls_req   = 1'b1;
    bus.i_ls_we    = 1'b0;
    bus.i_ls_addr  = 18'h00081;
    bus.i_ls_wdata = '0;
    bus.i_ls_bmask = 4'hF;

    repeat (2) step();
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_acks",
        {bus.o_if_ack, bus.o_ls_ack}, 0);
    chk("rst_if_rd", bus.o_if_rdata, 0);
    chk("rst_ls_rd", bus.o_ls_rdata, 0);
    chk("rst_pins", pins(), idle_pins());
    chk("rst_d", bus.o_sram_d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;

    // Both requesting continuously from reset.
    cyc = 0;
    rr_if = 1'b0;
    rr_ls = 1'b0;
    while (ack_port.size() < 4 && cyc < 40) begin
      step();
      cyc++;
      if (rr_if) begin
        bus.i_if_req = 1'b1;
        rr_if = 1'b0;
      end
      if (rr_ls) begin
        bus.i_ls_req = 1'b1;
        rr_ls = 1'b0;
      end
      chk("rr_not_both",
          bus.o_if_ack & bus.o_ls_ack, 0);
      if (bus.o_if_ack) begin
        ack_port.push_back(1'b0);
        ack_cyc.push_back(cyc);
        exp_rd[0] = ref_read(18'h00040);
        chk("rr_if_rd", bus.o_if_rdata,
            exp_rd[0]);
        bus.i_if_req = 1'b0;
        rr_if = 1'b1;
      end
      if (bus.o_ls_ack) begin
        ack_port.push_back(1'b1);
        ack_cyc.push_back(cyc);
        exp_rd[1] = ref_read(18'h00080);
        chk("rr_ls_rd", bus.o_ls_rdata,
            exp_rd[1]);
        bus.i_ls_req = 1'b0;
        rr_ls = 1'b1;
      end
    end
    drop_reqs();
    chk("rr_count", ack_port.size(), 4);
    for (int i = 0; i < ack_port.size(); i++) begin
      chk("rr_order", ack_port[i], (i % 2) == 0);
      if (i == 0) chk("rr_lat", ack_cyc[0], 3);
      else chk("rr_gap",
               ack_cyc[i] - ack_cyc[i-1], 4);
    end
    step();
    chk("rr_idle", bus.o_busy, 0);

    run_txn(1, 1, 18'h00100, 32'hDEADBEEF,
            4'b1111, 0);
    run_txn(0, 0, 18'h00101, 32'h0, 4'h0, 0);
    chk("if_deadbeef", bus.o_if_rdata,
        32'hDEADBEEF);

    run_txn(1, 1, 18'h00200, 32'h00AA0000,
            4'b0100, 0);
    chk("bm_byte2", sram_mem[18'h00201][7:0],
        8'hAA);

    run_txn(1, 1, 18'h00300, 32'h12345678,
            4'b0000, 0);
    run_txn(1, 1, 18'h3FFFF, 32'hCAFEF00D,
            4'b1111, 0);
    run_txn(0, 0, 18'h3FFFE, 32'h0, 4'h0, 0);
    chk("top_word", bus.o_if_rdata,
        32'hCAFEF00D);
    run_txn(1, 1, 18'h00401, 32'hA5A55A5A,
            4'b1011, 1);
    run_txn(1, 0, 18'h00400, 32'h0, 4'h0, 1);

    // Reset while the high half is in flight.
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 18'h00500;
    step();
    step();
    chk("rh_busy", bus.o_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rh_pins", pins(), idle_pins());
    chk("rh_busy0", bus.o_busy, 0);
    chk("rh_ack", bus.o_if_ack, 0);
    drop_reqs();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    chk("rh_rd", bus.o_if_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    step();
    step();
    chk("rh_noack",
        {bus.o_if_ack, bus.o_ls_ack, bus.o_busy},
        0);
    run_txn(0, 0, 18'h00500, 32'h0, 4'h0, 0);

    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, 255));
      run_txn(1'($urandom), 1'($urandom), a,
              $urandom, 4'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter_2port.md
Name: sram_arbiter_2port

Overview:
- Shares the single 16-bit external SRAM between two 32-bit requesters: the instruction-fetch port (IF, read-only) and the load/store port (LS, read/write).
- Arbitrates round-robin, sequences each 32-bit word as two 16-bit SRAM phases (low half, then high half), and returns a one-cycle ack per transaction.
- Sits between the fetch stage / LSU and the SRAM pins.
- Requesters stall on their own req until ack.

Parameters:
- ADDR_W, 18, SRAM halfword address width.
- RR_RESET_LAST, 0, port treated as last-granted at reset (0 = IF, 1 = LS).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_if_req  in  1  IF read request, held until o_if_ack
- i_if_addr  in  ADDR_W  IF halfword address
- o_if_rdata  out  32  IF read word, valid when o_if_ack
- o_if_ack  out  1  IF transaction done (1-cycle pulse)
- i_ls_req  in  1  LS request, held until o_ls_ack
- i_ls_we  in  1  1 = write, 0 = read
- i_ls_addr  in  ADDR_W  LS halfword address
- i_ls_wdata  in  32  LS write word
- i_ls_bmask  in  4  byte enables; [1:0] low half, [3:2] high half
- o_ls_rdata  out  32  LS read word, valid when o_ls_ack
- o_ls_ack  out  1  LS transaction done (1-cycle pulse)
- o_busy  out  1  transaction in flight (state != IDLE)
- o_sram_addr  out  ADDR_W  SRAM address
- i_sram_q  in  16  SRAM read data
- o_sram_d  out  16  SRAM write data
- o_sram_d_oe  out  1  data bus driver enable
- o_sram_ce_n / o_sram_we_n / o_sram_oe_n / o_sram_lb_n / o_sram_ub_n  out  1 each  SRAM strobes, active-low

Behaviour:
- Reset i_rst_n, asynchronous, active-low; clock i_clk.
- Reset values:
  - State IDLE.
  - All SRAM strobes 1; o_sram_d_oe 0; o_sram_addr 0; o_sram_d 0.
  - Both acks 0; both rdata 0; o_busy 0.
  - last_grant = RR_RESET_LAST.
- States:
  - IDLE: arbitrate.
  - RD_LO -> RD_HI -> ACK, for reads.
  - WR_LO -> WR_HI -> ACK, for writes.
  - ACK -> IDLE, unconditionally.
- Arbitration happens only in IDLE:
  - One request pending: grant it.
  - Both pending: grant the port != last_grant.
  - On grant, update last_grant and capture into registers: port id, we (IF forces 0), base = addr & ~1, wdata, bmask (IF forces 4'b1111).
- SRAM strobes and address are decoded from registered state and capture registers (Moore; no combinational path from req to pins).
- RD_LO:
  - addr = base; ce_n = 0, oe_n = 0, we_n = 1.
  - {ub_n, lb_n} = 00 (reads always fetch both bytes).
  - i_sram_q sampled into rdata[15:0] at the end of the cycle.
- RD_HI:
  - addr = base | 1; same strobes.
  - i_sram_q sampled into rdata[31:16].
- WR_LO:
  - addr = base; ce_n = 0, we_n = 0, oe_n = 1, d_oe = 1.
  - d = wdata[15:0]; {ub_n, lb_n} = ~bmask[1:0].
- WR_HI:
  - addr = base | 1; d = wdata[31:16]; {ub_n, lb_n} = ~bmask[3:2].
- ACK:
  - All strobes 1, d_oe 0.
  - Granted port's ack = 1; its rdata presents the captured word (write ack: rdata unchanged).
- Latency: a request seen in IDLE at edge N produces ack high during cycle N+3. Back-to-back throughput is one word per 4 cycles.
- rdata registers hold until the next read for that port completes.
- Boundary conditions:
  - req deasserted after grant: transaction completes, ack still pulses.
  - req still high in the ACK cycle: ignored; re-evaluated in the IDLE cycle that follows. Requesters drop req the cycle after ack.
  - bmask 0000 write: both phases run with lb_n = ub_n = 1; ack issued.
  - addr LSB set: ignored (forced even).
  - addr 0x3FFFE: high half at 0x3FFFF; no wrap beyond.
  - Reset mid-transaction: immediate return to IDLE, strobes deasserted asynchronously, no ack, transaction lost.

Decomposition:
- Package sram_arb_pkg:
  - sram_arb_state_e {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, ACK}.
  - port_id_e {PORT_IF = 0, PORT_LS = 1}.
  - FULL_MASK = 4'b1111.
- One sub-module, rr_arbiter2:
  - Inputs: req[1:0], grant_en.
  - Outputs: one-hot gnt[1:0].
  - Owns the last_grant register.

Test Plan:
- Reset, then LS write to addr 0x00100, wdata 0xDEADBEEF, bmask 1111 → WR_LO at 0x00100 drives d = 0xBEEF, lb_n = ub_n = 0; WR_HI at 0x00101 drives 0xDEAD; o_ls_ack pulses at N+3.
- IF read addr 0x00101, SRAM model returns 0xBEEF / 0xDEAD → addresses 0x00100, 0x00101; o_if_rdata = 0xDEADBEEF with o_if_ack at N+3.
- Both req high from reset (RR_RESET_LAST = 0), both held and re-raised → grant order LS, IF, LS, IF; acks 4 cycles apart, never simultaneous.
- LS write bmask 0100, wdata 0x00AA0000 → WR_LO lb_n = ub_n = 1; WR_HI lb_n = 0, ub_n = 1; memory byte 2 = 0xAA, others unchanged.
- Assert i_rst_n = 0 during RD_HI → strobes 1 before the next edge, no ack, state IDLE; a new IF request afterwards completes normally.
- LS req dropped the cycle after grant → transaction completes, o_ls_ack = 1 for exactly one cycle, o_busy 0 the following cycle.
